// File: rtl/alu_cmd_master.sv
// alu_cmd_master: host-side controller for the multi-cycle ALU start/done port.
// Accepts one command at a time, pulses alu_start, holds operands until
// alu_done, and queues result plus flags in a small response FIFO.
// Build option: define ALU_CMD_MASTER_TIMEOUT_EN to add the WAIT timeout path.
module alu_cmd_master #(
  parameter int N         = 8,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  // host command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_opcode,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  // ALU operation port
  output logic             alu_start,
  output logic [1:0]       alu_opcode,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [2*N-1:0]   alu_result,
  input  logic             alu_done,
  input  logic             alu_overflow,
  input  logic             alu_div_by_zero,
  input  logic             alu_zero,
  // host response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*N-1:0]   rsp_result,
  output logic [1:0]       rsp_opcode,
  output logic [2:0]       rsp_flags,
  output logic             rsp_timeout,
  output logic             err_stray_done
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               alu_start_q;
  logic [1:0]         op_q;
  logic [N-1:0]       a_q, b_q;
  logic               err_q;

  logic               accept;
  logic               push;
  logic               pop;
  logic [2*N-1:0]     push_result;
  logic [2:0]         push_flags;

  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [2*N-1:0]     res_mem [RSP_DEPTH];
  logic [1:0]         op_mem  [RSP_DEPTH];
  logic [2:0]         flg_mem [RSP_DEPTH];

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               push_timeout;
  logic               to_mem [RSP_DEPTH];
`else
  // TIMEOUT has no effect when the timeout path is compiled out.
  localparam int unused_timeout = TIMEOUT;
`endif

  // Command can be taken only when idle and a response slot is guaranteed.
  assign cmd_ready = (state_q == ST_IDLE) && (count_q < DEPTH_C);
  assign pop       = rsp_valid && rsp_ready;

  // Next-state logic for the issue/wait sequencer.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    push    = 1'b0;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    push_timeout = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (alu_done) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          push         = 1'b1;
          push_timeout = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  // A timeout entry carries a zero result and clear flags.
  assign push_result = push_timeout ? '0 : alu_result;
  assign push_flags  = push_timeout ? 3'b000
                                    : {alu_div_by_zero, alu_overflow, alu_zero};
`else
  assign push_result = alu_result;
  assign push_flags  = {alu_div_by_zero, alu_overflow, alu_zero};
`endif

  // Sequencer state, start pulse, held operands and stray-done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_start_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_start_q <= accept;
      if (accept) begin
        op_q <= cmd_opcode;
        a_q  <= cmd_a;
        b_q  <= cmd_b;
      end
      if (alu_done && (state_q != ST_WAIT)) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  // Cycles spent in WAIT for the current operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  // Response FIFO occupancy; simultaneous push and pop keep the count.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Response FIFO pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Response storage; a push never meets a full FIFO, so no guard is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr_q] <= push_result;
      op_mem[wr_ptr_q]  <= op_q;
      flg_mem[wr_ptr_q] <= push_flags;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
      to_mem[wr_ptr_q]  <= push_timeout;
`endif
    end
  end

  // Head outputs read zero while the FIFO is empty (and hence after reset).
  assign rsp_valid  = (count_q != '0);
  assign rsp_result = rsp_valid ? res_mem[rd_ptr_q] : '0;
  assign rsp_opcode = rsp_valid ? op_mem[rd_ptr_q]  : 2'b00;
  assign rsp_flags  = rsp_valid ? flg_mem[rd_ptr_q] : 3'b000;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_valid ? to_mem[rd_ptr_q] : 1'b0;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign alu_start      = alu_start_q;
  assign alu_opcode     = op_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign err_stray_done = err_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
// tb_alu_cmd_master: randomized self-checking bench for alu_cmd_master.
// The bench plays both host and ALU; expected responses come from an
// arithmetic ALU reference applied to the commands the host sent.
module tb_alu_cmd_master;

  localparam int N     = 8;
  localparam int W     = 2 * N;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic           clk;
  logic           rst_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_opcode;
  logic [N-1:0]   cmd_a, cmd_b;
  logic           alu_start;
  logic [1:0]     alu_opcode;
  logic [N-1:0]   alu_a, alu_b;
  logic [W-1:0]   alu_result;
  logic           alu_done;
  logic           alu_overflow, alu_div_by_zero, alu_zero;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_result;
  logic [1:0]     rsp_opcode;
  logic [2:0]     rsp_flags;
  logic           rsp_timeout;
  logic           err_stray_done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] res;
    logic [2:0]   flags;
    logic         to;
  } rsp_t;

  rsp_t exp_q[$];
  logic [1:0]   cur_op;
  logic [N-1:0] cur_a, cur_b;

  alu_cmd_master #(.N(N), .RSP_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_done(alu_done), .alu_overflow(alu_overflow),
    .alu_div_by_zero(alu_div_by_zero), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_opcode(rsp_opcode), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .err_stray_done(err_stray_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU reference: add, sub (wraps in 2N bits, overflow on borrow), mul, div.
  function automatic rsp_t alu_ref(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    rsp_t r;
    int unsigned ai, bi;
    logic dbz, ovf;
    ai = a; bi = b; dbz = 1'b0; ovf = 1'b0;
    r.op = op; r.to = 1'b0;
    case (op)
      2'd0: r.res = W'(ai + bi);
      2'd1: begin r.res = W'(ai - bi); ovf = (ai < bi); end
      2'd2: r.res = W'(ai * bi);
      default: begin
        if (bi == 0) begin r.res = '0; dbz = 1'b1; end
        else r.res = W'(ai / bi);
      end
    endcase
    r.flags = {dbz, ovf, (r.res == '0)};
    return r;
  endfunction

  // Host side: present a command, wait for acceptance, check the start pulse.
  task automatic issue_cmd(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int waited = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    while (cmd_ready !== 1'b1 && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    if (waited >= 200) begin
      checks++; errors++;
      $display("FAIL accept_wait: cmd_ready=%b never rose within 200 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_opcode = 2'($urandom); cmd_a = N'($urandom); cmd_b = N'($urandom);
    cur_op = op; cur_a = a; cur_b = b;
    checks++;
    if (alu_start !== 1'b1 || alu_opcode !== op || alu_a !== a || alu_b !== b) begin
      errors++;
      $display("FAIL issue: start=%b op=%0d a=%0d b=%0d, required start=1 op=%0d a=%0d b=%0d",
               alu_start, alu_opcode, alu_a, alu_b, op, a, b);
    end
  endtask

  // ALU side: after lat cycles of holding, pulse done with the computed result.
  task automatic respond(input int lat);
    rsp_t r;
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      cmd_a = N'($urandom); cmd_b = N'($urandom); cmd_opcode = 2'($urandom);
      checks++;
      if (alu_start !== 1'b0 || alu_opcode !== cur_op || alu_a !== cur_a || alu_b !== cur_b) begin
        errors++;
        $display("FAIL hold: start=%b op=%0d a=%0d b=%0d, required start=0 op=%0d a=%0d b=%0d",
                 alu_start, alu_opcode, alu_a, alu_b, cur_op, cur_a, cur_b);
      end
    end
    r = alu_ref(alu_opcode, alu_a, alu_b);
    alu_done = 1'b1; alu_result = r.res;
    {alu_div_by_zero, alu_overflow, alu_zero} = r.flags;
    @(posedge clk); #1;
    alu_done = 1'b0; alu_result = W'($urandom);
    {alu_div_by_zero, alu_overflow, alu_zero} = 3'($urandom);
    exp_q.push_back(alu_ref(cur_op, cur_a, cur_b));
    checks++;
    if (rsp_valid !== 1'b1 || cmd_ready !== (exp_q.size() < DEPTH)) begin
      errors++;
      $display("FAIL after_done: rsp_valid=%b cmd_ready=%b, required rsp_valid=1 cmd_ready=%b",
               rsp_valid, cmd_ready, (exp_q.size() < DEPTH));
    end
  endtask

  // Host side: compare the FIFO head with the oldest expected entry, then pop.
  task automatic pop_check();
    rsp_t e;
    e = exp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== e.res || rsp_opcode !== e.op ||
        rsp_flags !== e.flags || rsp_timeout !== e.to) begin
      errors++;
      $display("FAIL response: valid=%b res=%0d op=%0d flags=%b to=%b, required valid=1 res=%0d op=%0d flags=%b to=%b",
               rsp_valid, rsp_result, rsp_opcode, rsp_flags, rsp_timeout, e.res, e.op, e.flags, e.to);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) pop_check();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained_empty: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input int lat);
    issue_cmd(op, a, b);
    respond(lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    alu_result = '0; alu_done = 1'b0; alu_overflow = 1'b0; alu_div_by_zero = 1'b0;
    alu_zero = 1'b0; rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (alu_start !== 1'b0 || alu_opcode !== 2'd0 || alu_a !== '0 || alu_b !== '0 ||
        rsp_valid !== 1'b0 || rsp_result !== '0 || rsp_opcode !== 2'd0 ||
        rsp_flags !== 3'd0 || rsp_timeout !== 1'b0 || err_stray_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b a=%0d rsp_valid=%b res=%0d err=%b, required all 0",
               alu_start, alu_a, rsp_valid, rsp_result, err_stray_done);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_add();
    run_op(2'd0, 8'd5, 8'd3, 3);
    checks++;
    if (rsp_result !== 16'd8 || rsp_flags !== 3'b000 || rsp_opcode !== 2'd0) begin
      errors++;
      $display("FAIL add_5_3: res=%0d flags=%b op=%0d, required 8 000 0", rsp_result, rsp_flags, rsp_opcode);
    end
    drain_all();
  endtask

  task automatic test_mul_div0();
    run_op(2'd2, 8'd255, 8'd255, 2);
    checks++;
    if (rsp_result !== 16'd65025) begin
      errors++;
      $display("FAIL mul_255: res=%0d, required 65025", rsp_result);
    end
    pop_check();
    run_op(2'd3, 8'd9, 8'd0, 4);
    checks++;
    if (rsp_result !== 16'd0 || rsp_flags !== 3'b101) begin
      errors++;
      $display("FAIL div_by_zero: res=%0d flags=%b, required 0 101", rsp_result, rsp_flags);
    end
    drain_all();
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < DEPTH; i++) run_op(2'd0, N'(10 + i), N'(i), 1 + i);
    cmd_valid = 1'b1; cmd_opcode = 2'd0; cmd_a = 8'd100; cmd_b = 8'd1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_ready !== 1'b0 || alu_start !== 1'b0) begin
        errors++;
        $display("FAIL full_stall: cmd_ready=%b start=%b, required 0 0", cmd_ready, alu_start);
      end
      @(posedge clk); #1;
    end
    pop_check();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_pop: cmd_ready=%b, required 1", cmd_ready);
    end
    run_op(2'd0, 8'd100, 8'd1, 2);
    drain_all();
  endtask

  task automatic test_operand_hold();
    issue_cmd(2'd1, 8'd77, 8'd33);
    cmd_a = 8'd1; cmd_b = 8'd2; cmd_opcode = 2'd3;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (alu_a !== 8'd77 || alu_b !== 8'd33 || alu_opcode !== 2'd1) begin
        errors++;
        $display("FAIL operand_hold: a=%0d b=%0d op=%0d, required 77 33 1", alu_a, alu_b, alu_opcode);
      end
    end
    respond(1);
    drain_all();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      logic [N-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = N'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      if (exp_q.size() == DEPTH) pop_check();
      run_op(op, a, b, int'($urandom_range(1, 5)));
      if ($urandom_range(0, 1) == 1) pop_check();
    end
    drain_all();
  endtask

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    rsp_t e;
    issue_cmd(2'd2, 8'd6, 8'd7);
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: response %0d cycles after accept cycle, required %0d", n, TO + 1);
    end
    e.op = 2'd2; e.res = '0; e.flags = 3'b000; e.to = 1'b1;
    exp_q.push_back(e);
    pop_check();
    alu_done = 1'b1; alu_result = 16'hBEEF;
    @(posedge clk); #1;
    alu_done = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (err_stray_done !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_done: err=%b rsp_valid=%b, required 1 0", err_stray_done, rsp_valid);
    end
  endtask
`endif

  task automatic test_stray_done();
    checks++;
    if (err_stray_done !== 1'b0) begin
      errors++;
      $display("FAIL stray_pre: err=%b, required 0", err_stray_done);
    end
    alu_done = 1'b1; alu_result = 16'h1234;
    @(posedge clk); #1;
    alu_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (err_stray_done !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_done: err=%b rsp_valid=%b cmd_ready=%b, required 1 0 1",
               err_stray_done, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    run_op(2'd0, 8'd1, 8'd2, 1);
    run_op(2'd1, 8'd9, 8'd4, 2);
    issue_cmd(2'd2, 8'd3, 8'd3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || alu_start !== 1'b0 || alu_a !== '0 || err_stray_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait: rsp_valid=%b start=%b a=%0d err=%b, required 0 0 0 0",
               rsp_valid, alu_start, alu_a, err_stray_done);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_ready: cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    run_op(2'd0, 8'd40, 8'd2, 2);
    drain_all();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_div0();
    test_back_pressure();
    test_operand_hold();
    test_random();
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_stray_done();
`endif
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
